// File: rtl/mobo_adc_readout_fsm.sv
// MOBO readout sequencer: answers the exposure FSM's readout request, walks every
// pixel row through settle / sample-hold / convert / channel-read, then releases the frame.
module mobo_adc_readout_fsm #(
  parameter int C_NUM_ROWS = 160,
  parameter int C_NUM_CH   = 18,
  parameter int C_SETTLE   = 4,
  parameter int C_SAMPLE   = 8,
  parameter int C_CONV     = 20
) (
  input  logic        CLK_ADC,
  input  logic        RESET_B,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  input  logic        FIFO_AFULL,
  output logic [7:0]  ROW_ADDR,
  output logic        ROW_EN,
  output logic        SH,
  output logic        ADC_SOC,
  output logic        ADC_RD,
  output logic [4:0]  CH_ADDR,
  output logic [31:0] FRAME_CNT,
  output logic [8:1]  fsm_stat
);

  localparam int C_PH_MAX = (C_SETTLE > C_SAMPLE) ?
                            ((C_SETTLE > C_CONV) ? C_SETTLE : C_CONV) :
                            ((C_SAMPLE > C_CONV) ? C_SAMPLE : C_CONV);
  localparam int PH_W = $clog2(C_PH_MAX) + 1;

  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(C_SETTLE - 1);
  localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(C_SAMPLE - 1);
  localparam logic [PH_W-1:0] CONV_LAST   = PH_W'(C_CONV - 1);
  localparam logic [7:0]      ROW_LAST    = 8'(C_NUM_ROWS - 1);
  localparam logic [4:0]      CH_LAST     = 5'(C_NUM_CH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CONV   = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_REL    = 3'd6;

  localparam logic [7:0] STAT_RESET = 8'b10101010;

  function automatic logic [7:0] stat_code(input logic [2:0] s);
    case (s)
      S_IDLE:   stat_code = 8'b11110001;
      S_SETTLE: stat_code = 8'b11110010;
      S_SAMPLE: stat_code = 8'b11110100;
      S_CONV:   stat_code = 8'b11111000;
      S_READ:   stat_code = 8'b11110011;
      S_DONE:   stat_code = 8'b11110101;
      S_REL:    stat_code = 8'b11110110;
      default:  stat_code = 8'b11110001;
    endcase
  endfunction

  logic            f1_meta_q, f1s_q, f0a_meta_q, f0as_q;
  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [7:0]      row_q, row_d;
  logic [4:0]      ch_q, ch_d;
  logic            ack1_q, ack1_d;
  logic            ind0_q, ind0_d;
  logic            row_en_q, row_en_d;
  logic            sh_q, sh_d;
  logic            soc_q, soc_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]      stat_q, stat_d;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    row_d       = row_q;
    ch_d        = ch_q;
    ack1_d      = ack1_q;
    ind0_d      = ind0_q;
    row_en_d    = row_en_q;
    sh_d        = sh_q;
    soc_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      // ack1_q stays high until the release, so a request is only re-armed once F1s has dropped
      S_IDLE: begin
        if (f1s_q && !ack1_q) begin
          state_d  = S_SETTLE;
          row_d    = 8'd0;
          ack1_d   = 1'b1;
          row_en_d = 1'b1;
          ph_d     = '0;
        end
      end
      S_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          ph_d    = '0;
          sh_d    = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SAMPLE: begin
        if (ph_q == SAMPLE_LAST) begin
          state_d = S_CONV;
          ph_d    = '0;
          sh_d    = 1'b0;
          soc_d   = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_CONV: begin
        if (ph_q == CONV_LAST) begin
          state_d = S_READ;
          ph_d    = '0;
          ch_d    = 5'd0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      // ADC_RD is the same-cycle qualified strobe, so a stalled cycle never advances CH_ADDR
      S_READ: begin
        if (!FIFO_AFULL) begin
          if (ch_q == CH_LAST) begin
            ch_d = 5'd0;
            if (row_q < ROW_LAST) begin
              row_d   = row_q + 8'd1;
              state_d = S_SETTLE;
            end else begin
              state_d     = S_DONE;
              row_en_d    = 1'b0;
              ind0_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 32'd1;
            end
          end else begin
            ch_d = ch_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        if (f0as_q && !f1s_q) begin
          state_d = S_REL;
          ind0_d  = 1'b0;
          ack1_d  = 1'b0;
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        ph_d     = '0;
        row_d    = 8'd0;
        ch_d     = 5'd0;
        ack1_d   = 1'b0;
        ind0_d   = 1'b0;
        row_en_d = 1'b0;
        sh_d     = 1'b0;
      end
    endcase
    stat_d = stat_code(state_d);
  end

  always_ff @(posedge CLK_ADC or negedge RESET_B) begin
    if (!RESET_B) begin
      f1_meta_q   <= 1'b0;
      f1s_q       <= 1'b0;
      f0a_meta_q  <= 1'b0;
      f0as_q      <= 1'b0;
      state_q     <= S_IDLE;
      ph_q        <= '0;
      row_q       <= 8'd0;
      ch_q        <= 5'd0;
      ack1_q      <= 1'b0;
      ind0_q      <= 1'b0;
      row_en_q    <= 1'b0;
      sh_q        <= 1'b0;
      soc_q       <= 1'b0;
      frame_cnt_q <= 32'd0;
      stat_q      <= STAT_RESET;
    end else begin
      f1_meta_q   <= FSMIND1;
      f1s_q       <= f1_meta_q;
      f0a_meta_q  <= FSMIND0ACK;
      f0as_q      <= f0a_meta_q;
      state_q     <= state_d;
      ph_q        <= ph_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      ack1_q      <= ack1_d;
      ind0_q      <= ind0_d;
      row_en_q    <= row_en_d;
      sh_q        <= sh_d;
      soc_q       <= soc_d;
      frame_cnt_q <= frame_cnt_d;
      stat_q      <= stat_d;
    end
  end

  assign FSMIND1ACK = ack1_q;
  assign FSMIND0    = ind0_q;
  assign ROW_ADDR   = row_q;
  assign ROW_EN     = row_en_q;
  assign SH         = sh_q;
  assign ADC_SOC    = soc_q;
  assign ADC_RD     = (state_q == S_READ) && !FIFO_AFULL;
  assign CH_ADDR    = ch_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign fsm_stat   = stat_q;

endmodule
